// File: rtl/program_memory_loader.sv
// -----------------------------------------------------------------------------
// program_memory_loader
//
// Writer side of the writable program memory. Accepts a framed byte stream
// (typically from a UART receiver), assembles 32-bit instruction words MSB
// first and issues one-cycle write strobes into the program memory, using the
// same byte addressing as the fetch path (word index = MemAddress[31:2]).
//
// Frame: LEN_HI, LEN_LO (word count N), 4*N payload bytes, then one checksum
// byte equal to the XOR of every preceding byte of the frame.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous reset, active-high
//   Start      in   one-cycle pulse that begins a frame load (ignored while Busy)
//   ByteIn     in   [7:0] stream data byte
//   ByteValid  in   ByteIn is valid this cycle
//   ByteReady  out  loader accepts a byte this cycle (registered)
//   MemWrite   out  one-cycle write strobe to the program memory
//   MemAddress out  [DATA_WIDTH-1:0] byte address of the word being written
//   MemData    out  [DATA_WIDTH-1:0] instruction word being written
//   Busy       out  a load is in progress; the CPU is held
//   Done       out  sticky: last frame loaded with a correct checksum
//   Error      out  sticky: last frame had a bad length or bad checksum
//   WordCount  out  [15:0] words written in the current or last frame
// -----------------------------------------------------------------------------
module program_memory_loader #(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic [15:0]           WordCount
);

  // Largest frame length that still fits the target memory.
  localparam logic [15:0] DEPTH_LIMIT = 16'(MEMORY_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  // The states that consume stream bytes are exactly the states in which a
  // load is in progress, so one predicate drives both ByteReady and Busy.
  function automatic logic in_frame(input state_t s);
    case (s)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK: in_frame = 1'b1;
      default:                             in_frame = 1'b0;
    endcase
  endfunction

  // Running XOR checksum of one more stream byte.
  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    xor_fold = acc ^ b;
  endfunction

  state_t                  state_r;
  state_t                  state_s;

  logic                    ready_r;
  logic                    write_r;
  logic [DATA_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   data_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    error_r;
  logic [15:0]             count_r;
  logic [7:0]              acc_r;
  logic [7:0]              len_hi_r;
  logic [15:0]             len_r;
  logic [23:0]             word_r;
  logic [1:0]              byte_cnt_r;

  logic                    accept_s;
  logic                    restart_s;
  logic [15:0]             frame_len_s;
  logic                    last_word_s;
  logic                    word_done_s;
  logic [DATA_WIDTH-1:0]   word_addr_s;

  // Handshake, restart qualification and word-boundary decode.
  always_comb begin
    accept_s    = ByteValid & ready_r;
    restart_s   = Start & ~in_frame(state_r);
    frame_len_s = {len_hi_r, ByteIn};
    // count_r holds the index of the word being assembled.
    last_word_s = ((count_r + 16'd1) == len_r);
    word_done_s = accept_s && (state_r == S_DATA) && (byte_cnt_r == 2'd3);
    word_addr_s = BASE_ADDRESS + {{(DATA_WIDTH-18){1'b0}}, count_r, 2'b00};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) begin
          state_s = S_LEN_HI;
        end else begin
          state_s = state_r;
        end
      end
      S_LEN_HI: begin
        if (accept_s) begin
          state_s = S_LEN_LO;
        end else begin
          state_s = S_LEN_HI;
        end
      end
      S_LEN_LO: begin
        if (!accept_s) begin
          state_s = S_LEN_LO;
        end else if (frame_len_s > DEPTH_LIMIT) begin
          state_s = S_ERROR;
        end else if (frame_len_s == 16'd0) begin
          state_s = S_CHECK;
        end else begin
          state_s = S_DATA;
        end
      end
      S_DATA: begin
        if (word_done_s && last_word_s) begin
          state_s = S_CHECK;
        end else begin
          state_s = S_DATA;
        end
      end
      S_CHECK: begin
        if (!accept_s) begin
          state_s = S_CHECK;
        end else if (ByteIn == acc_r) begin
          state_s = S_DONE;
        end else begin
          state_s = S_ERROR;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Status flags: registered copies of the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      ready_r <= in_frame(state_s);
      busy_r  <= in_frame(state_s);
      done_r  <= (state_s == S_DONE);
      error_r <= (state_s == S_ERROR);
    end
  end

  // Length capture, checksum accumulation and word assembly.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r      <= 8'h00;
      len_hi_r   <= 8'h00;
      len_r      <= 16'h0000;
      word_r     <= 24'h00_0000;
      byte_cnt_r <= 2'd0;
    end else if (restart_s) begin
      acc_r      <= 8'h00;
      len_hi_r   <= 8'h00;
      len_r      <= 16'h0000;
      word_r     <= 24'h00_0000;
      byte_cnt_r <= 2'd0;
    end else if (accept_s && (state_r != S_CHECK)) begin
      acc_r <= xor_fold(acc_r, ByteIn);
      case (state_r)
        S_LEN_HI: len_hi_r <= ByteIn;
        S_LEN_LO: len_r    <= frame_len_s;
        S_DATA: begin
          word_r     <= {word_r[15:0], ByteIn};
          byte_cnt_r <= byte_cnt_r + 2'd1;
        end
        default: len_r <= len_r;
      endcase
    end else begin
      acc_r <= acc_r;
    end
  end

  // Memory write port: strobe, address, data and word count move together on
  // the edge that accepts the fourth byte of a word.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_r <= 1'b0;
      addr_r  <= BASE_ADDRESS;
      data_r  <= {DATA_WIDTH{1'b0}};
      count_r <= 16'h0000;
    end else if (restart_s) begin
      write_r <= 1'b0;
      count_r <= 16'h0000;
    end else if (word_done_s) begin
      write_r <= 1'b1;
      addr_r  <= word_addr_s;
      data_r  <= {word_r, ByteIn};
      count_r <= count_r + 16'd1;
    end else begin
      write_r <= 1'b0;
    end
  end

  assign ByteReady  = ready_r;
  assign MemWrite   = write_r;
  assign MemAddress = addr_r;
  assign MemData    = data_r;
  assign Busy       = busy_r;
  assign Done       = done_r;
  assign Error      = error_r;
  assign WordCount  = count_r;

endmodule

// File: tb/tb_program_memory_loader.sv
// -----------------------------------------------------------------------------
// tb_program_memory_loader
//
// Drives two loader instances with the same stream: one based at address 0,
// one based at 0x0040_0000. Frames come from a table of {bytes, expected
// outcome}; multi-cycle corner cases are written out by hand below it.
// -----------------------------------------------------------------------------
module tb_program_memory_loader;

  localparam logic [31:0] BASE_B = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteValid;

  logic        ready_a, write_a, busy_a, done_a, error_a;
  logic [31:0] addr_a, data_a;
  logic [15:0] wc_a;
  logic        ready_b, write_b, busy_b, done_b, error_b;
  logic [31:0] addr_b, data_b;
  logic [15:0] wc_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];

  program_memory_loader #(.MEMORY_DEPTH(32), .DATA_WIDTH(32), .BASE_ADDRESS(32'h0000_0000)) dut_a (
    .clk(clk), .reset(reset), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ready_a), .MemWrite(write_a), .MemAddress(addr_a), .MemData(data_a),
    .Busy(busy_a), .Done(done_a), .Error(error_a), .WordCount(wc_a)
  );

  program_memory_loader #(.MEMORY_DEPTH(32), .DATA_WIDTH(32), .BASE_ADDRESS(BASE_B)) dut_b (
    .clk(clk), .reset(reset), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ready_b), .MemWrite(write_b), .MemAddress(addr_b), .MemData(data_b),
    .Busy(busy_b), .Done(done_b), .Error(error_b), .WordCount(wc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every cycle in which a write strobe is high.
  always @(negedge clk) begin
    if (write_a) begin
      qa_addr.push_back(addr_a);
      qa_data.push_back(data_a);
    end
    if (write_b) begin
      qb_addr.push_back(addr_b);
      qb_data.push_back(data_b);
    end
  end

  typedef struct {
    string        name;
    int           nbytes;
    logic [127:0] stream;    // bytes in order, first byte in the top octet
    bit           throttle;
    logic         exp_done;
    logic         exp_error;
    logic [15:0]  exp_wc;
    int           exp_nwr;
    logic [31:0]  exp_w0;
    logic [31:0]  exp_w1;
  } frame_t;

  frame_t frames [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_queues();
    qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that sampled Start.
  task automatic pulse_start();
    Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  // Presents one byte and holds it until accepted; returns #1 after the
  // accepting edge. Throttled mode idles ByteValid for one cycle first.
  task automatic send_byte(input logic [7:0] b, input bit throttle);
    bit accepted;
    accepted = 1'b0;
    if (throttle) begin
      ByteValid = 1'b0;
      @(posedge clk); #1;
    end
    ByteIn    = b;
    ByteValid = 1'b1;
    for (int k = 0; k < 20 && !accepted; k++) begin
      @(negedge clk);
      if (ready_a) accepted = 1'b1;
      @(posedge clk); #1;
    end
    ByteValid = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte %h never accepted", b);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [7:0] b;

    // Nominal checksum: 00^02^20^08^00^05^01^09^50^20 = 0x57.
    // Single word: 00^01^DE^AD^BE^EF = 0x23.
    frames[0] = '{"nominal",   11, 128'h0002_2008_0005_0109_5020_5700_0000_0000, 1'b0,
                  1'b1, 1'b0, 16'd2, 2, 32'h2008_0005, 32'h0109_5020};
    frames[1] = '{"oversize",   2, 128'h0021_0000_0000_0000_0000_0000_0000_0000, 1'b0,
                  1'b0, 1'b1, 16'd0, 0, 32'h0, 32'h0};
    frames[2] = '{"badsum",    11, 128'h0002_2008_0005_0109_5020_FF00_0000_0000, 1'b0,
                  1'b0, 1'b1, 16'd2, 2, 32'h2008_0005, 32'h0109_5020};
    frames[3] = '{"throttled", 11, 128'h0002_2008_0005_0109_5020_5700_0000_0000, 1'b1,
                  1'b1, 1'b0, 16'd2, 2, 32'h2008_0005, 32'h0109_5020};
    frames[4] = '{"zerolen",    3, 128'h0000_0000_0000_0000_0000_0000_0000_0000, 1'b0,
                  1'b1, 1'b0, 16'd0, 0, 32'h0, 32'h0};
    frames[5] = '{"oneword",    7, 128'h0001_DEAD_BEEF_2300_0000_0000_0000_0000, 1'b0,
                  1'b1, 1'b0, 16'd1, 1, 32'hDEAD_BEEF, 32'h0};

    reset = 1'b1; Start = 1'b0; ByteIn = 8'h00; ByteValid = 1'b0;
    idle(3);
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'd0, ready_a}, 32'd0);
    chk("rst_write", {31'd0, write_a}, 32'd0);
    chk("rst_addr_a", addr_a, 32'h0000_0000);
    chk("rst_addr_b", addr_b, BASE_B);
    chk("rst_data", data_a, 32'h0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_error", {31'd0, error_a}, 32'd0);
    chk("rst_wc", {16'd0, wc_a}, 32'd0);
    idle(1);

    // Busy and ByteReady rise on the edge that samples Start.
    pulse_start();
    chk("start_busy", {31'd0, busy_a}, 32'd1);
    chk("start_ready", {31'd0, ready_a}, 32'd1);
    reset = 1'b1; idle(1); reset = 1'b0;

    // Table-driven frames.
    for (int f = 0; f < 6; f++) begin
      clear_queues();
      pulse_start();
      chk({frames[f].name, "_flags_clear"}, {30'd0, done_a, error_a}, 32'd0);
      for (int i = 0; i < frames[f].nbytes; i++) begin
        b = frames[f].stream[127 - 8*i -: 8];
        send_byte(b, frames[f].throttle);
      end
      // Busy is already low right after the final accepted byte.
      chk({frames[f].name, "_busy"}, {31'd0, busy_a}, 32'd0);
      idle(2);
      chk({frames[f].name, "_ready"}, {31'd0, ready_a}, 32'd0);
      chk({frames[f].name, "_done"}, {31'd0, done_a}, {31'd0, frames[f].exp_done});
      chk({frames[f].name, "_error"}, {31'd0, error_a}, {31'd0, frames[f].exp_error});
      chk({frames[f].name, "_wc"}, {16'd0, wc_a}, {16'd0, frames[f].exp_wc});
      chk({frames[f].name, "_done_b"}, {31'd0, done_b}, {31'd0, frames[f].exp_done});
      chk({frames[f].name, "_nwr_a"}, qa_addr.size(), frames[f].exp_nwr);
      chk({frames[f].name, "_nwr_b"}, qb_addr.size(), frames[f].exp_nwr);
      for (int w = 0; w < frames[f].exp_nwr && w < qa_addr.size() && w < qb_addr.size(); w++) begin
        chk({frames[f].name, "_addr_a"}, qa_addr[w], 32'(4 * w));
        chk({frames[f].name, "_addr_b"}, qb_addr[w], BASE_B + 32'(4 * w));
        chk({frames[f].name, "_data_a"}, qa_data[w], (w == 0) ? frames[f].exp_w0 : frames[f].exp_w1);
        chk({frames[f].name, "_data_b"}, qb_data[w], (w == 0) ? frames[f].exp_w0 : frames[f].exp_w1);
      end
    end

    // Bytes offered while idle in DONE are ignored.
    clear_queues();
    ByteIn = 8'hA5; ByteValid = 1'b1;
    idle(4);
    ByteValid = 1'b0;
    chk("ignore_done", {31'd0, done_a}, 32'd1);
    chk("ignore_wc", {16'd0, wc_a}, 32'd1);
    chk("ignore_nwr", qa_addr.size(), 0);

    // Write strobe timing: high exactly in the cycle after the 4th byte.
    clear_queues();
    pulse_start();
    send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h20, 1'b0); send_byte(8'h08, 1'b0); send_byte(8'h00, 1'b0);
    chk("wr_pre", {31'd0, write_a}, 32'd0);
    send_byte(8'h05, 1'b0);
    chk("wr_pulse", {31'd0, write_a}, 32'd1);
    chk("wr_wc", {16'd0, wc_a}, 32'd1);
    send_byte(8'h01, 1'b0); send_byte(8'h09, 1'b0);
    chk("wr_one_pulse", {31'd0, write_a}, 32'd0);
    chk("mid_writes", qa_addr.size(), 1);

    // Reset together with Start after 6 payload bytes: reset wins, back to IDLE.
    reset = 1'b1; Start = 1'b1;
    idle(1);
    reset = 1'b0; Start = 1'b0;
    chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready_a}, 32'd0);
    chk("mid_rst_wc", {16'd0, wc_a}, 32'd0);
    idle(2);
    chk("mid_rst_idle", {31'd0, busy_a}, 32'd0);
    chk("mid_rst_nwr", qa_addr.size(), 1);

    // Full frame again, with a stray Start pulsed mid-frame.
    clear_queues();
    pulse_start();
    for (int i = 0; i < 11; i++) begin
      b = frames[0].stream[127 - 8*i -: 8];
      if (i == 4) Start = 1'b1;
      send_byte(b, 1'b0);
      Start = 1'b0;
    end
    idle(1);
    chk("restart_done", {31'd0, done_a}, 32'd1);
    chk("restart_error", {31'd0, error_a}, 32'd0);
    chk("restart_wc", {16'd0, wc_a}, 32'd2);
    chk("restart_nwr", qa_addr.size(), 2);
    if (qa_data.size() == 2) begin
      chk("restart_w1", qa_data[1], 32'h0109_5020);
    end

    // Length equal to the memory depth is accepted.
    pulse_start();
    send_byte(8'h00, 1'b0); send_byte(8'h20, 1'b0);
    chk("maxlen_error", {31'd0, error_a}, 32'd0);
    chk("maxlen_busy", {31'd0, busy_a}, 32'd1);
    chk("maxlen_ready", {31'd0, ready_a}, 32'd1);
    reset = 1'b1; idle(1); reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
